pipe_arbiter: RTL and testbench

PIPE_ARBITER -- requirements
Module: pipe_arbiter

---
 rtl/pipe_arbiter.sv | 134 +++++++++++++
 tb/tb_pipe_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_arbiter.sv
// Round-robin arbiter feeding a fixed-latency (a+b)*c pipe; a tag FIFO routes
// in-order pipe results back to the requester that issued them.
module pipe_arbiter #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [30:0] req0_a,
  input  logic [30:0] req0_b,
  input  logic [31:0] req0_c,
  input  logic [30:0] req1_a,
  input  logic [30:0] req1_b,
  input  logic [31:0] req1_c,
  output logic        pipe_in_valid,
  output logic [30:0] pipe_in_1,
  output logic [30:0] pipe_in_2,
  output logic [31:0] pipe_in_3,
  input  logic        pipe_out_valid,
  input  logic [63:0] pipe_out,
  output logic        resp0_valid,
  output logic        resp1_valid,
  output logic [63:0] resp_data,
  output logic [3:0]  inflight,
  output logic        err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [30:0] a;
    logic [30:0] b;
    logic [31:0] c;
  } op_t;

  logic             last_grant;
  logic [DEPTH-1:0] tag_mem;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic grant0_c, grant1_c, not_full_c;
  logic acc0_c, acc1_c, push_c, pop_c, head_tag_c;
  op_t  sel_op_c;

  // Round-robin grant: on a tie the requester that did not win last goes.
  always_comb begin
    grant0_c = 1'b0;
    grant1_c = 1'b0;
    case ({req1_valid, req0_valid})
      2'b01:   grant0_c = 1'b1;
      2'b10:   grant1_c = 1'b1;
      2'b11: begin
        if (last_grant) grant0_c = 1'b1;
        else            grant1_c = 1'b1;
      end
      default: ;
    endcase
  end

  // Full FIFO blocks issue even when a pop frees a slot in the same cycle.
  assign not_full_c = (count < CNT_W'(DEPTH));
  assign req0_ready = rst_n & grant0_c & not_full_c;
  assign req1_ready = rst_n & grant1_c & not_full_c;

  assign acc0_c     = req0_valid & req0_ready;
  assign acc1_c     = req1_valid & req1_ready;
  assign push_c     = acc0_c | acc1_c;
  assign pop_c      = pipe_out_valid & (count != '0);
  assign head_tag_c = tag_mem[rd_ptr];
  assign sel_op_c   = acc1_c ? op_t'{req1_a, req1_b, req1_c} : op_t'{req0_a, req0_b, req0_c};

  // Issue register toward the pipe; operands hold when nothing is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_in_valid <= 1'b0;
      pipe_in_1     <= '0;
      pipe_in_2     <= '0;
      pipe_in_3     <= '0;
      last_grant    <= 1'b1;
    end else begin
      pipe_in_valid <= push_c;
      if (push_c) begin
        pipe_in_1  <= sel_op_c.a;
        pipe_in_2  <= sel_op_c.b;
        pipe_in_3  <= sel_op_c.c;
        last_grant <= acc1_c;
      end
    end
  end

  // Tag FIFO: one bit per in-flight result naming its requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_mem <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      if (push_c) begin
        tag_mem[wr_ptr] <= acc1_c;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Response routing and sticky error on a result with no owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      resp_data   <= '0;
      err         <= 1'b0;
    end else begin
      resp0_valid <= pop_c & ~head_tag_c;
      resp1_valid <= pop_c & head_tag_c;
      if (pop_c) resp_data <= pipe_out;
      if (pipe_out_valid && count == '0) err <= 1'b1;
    end
  end

  assign inflight = 4'(count);

endmodule

// File: tb/tb_pipe_arbiter.sv
// Directed bench for pipe_arbiter with a behavioural 6-cycle (a+b)*c pipe and
// a scoreboard of expected responses filled at accept time.
module tb_pipe_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [30:0] req0_a, req0_b, req1_a, req1_b;
  logic [31:0] req0_c, req1_c;
  logic        pipe_in_valid;
  logic [30:0] pipe_in_1, pipe_in_2;
  logic [31:0] pipe_in_3;
  logic        pipe_out_valid;
  logic [63:0] pipe_out;
  logic        resp0_valid, resp1_valid;
  logic [63:0] resp_data;
  logic [3:0]  inflight;
  logic        err;

  pipe_arbiter #(.DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_c(req0_c),
    .req1_a(req1_a), .req1_b(req1_b), .req1_c(req1_c),
    .pipe_in_valid(pipe_in_valid), .pipe_in_1(pipe_in_1),
    .pipe_in_2(pipe_in_2), .pipe_in_3(pipe_in_3),
    .pipe_out_valid(pipe_out_valid), .pipe_out(pipe_out),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
    .resp_data(resp_data), .inflight(inflight), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        tag;
    logic [63:0] data;
  } sb_t;

  typedef struct packed {
    int unsigned c;
    logic [63:0] data;
  } pq_t;

  sb_t         sb[$];
  pq_t         pq[$];
  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  bit          hold = 1'b0;
  int          rel_req = 0, rel_done = 0;
  int          spur_req = 0, spur_done = 0;

  function automatic logic [63:0] mac(input logic [30:0] a, input logic [30:0] b,
                                      input logic [31:0] c);
    return 64'({1'b0, a} + {1'b0, b}) * 64'(c);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Mid-cycle: record accepts, score responses, then advance the pipe model.
  task automatic monitor();
    sb_t e;
    pq_t p;
    cyc++;
    if (!rst_n) begin
      sb.delete();
      pq.delete();
      pipe_out_valid = 1'b0;
      return;
    end
    if (req0_valid && req0_ready) begin
      e.tag = 1'b0; e.data = mac(req0_a, req0_b, req0_c); sb.push_back(e);
    end
    if (req1_valid && req1_ready) begin
      e.tag = 1'b1; e.data = mac(req1_a, req1_b, req1_c); sb.push_back(e);
    end
    if (resp0_valid || resp1_valid) begin
      chk("resp_onehot", 64'(resp0_valid & resp1_valid), 64'(0));
      chk("resp_expected", 64'(sb.size() > 0), 64'(1));
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("resp_tag", 64'(resp1_valid), 64'(e.tag));
        chk("resp_data", resp_data, e.data);
      end
    end
    if (pipe_in_valid) begin
      p.c = cyc; p.data = mac(pipe_in_1, pipe_in_2, pipe_in_3); pq.push_back(p);
    end
    pipe_out_valid = 1'b0;
    if (spur_req != spur_done) begin
      spur_done++;
      pipe_out_valid = 1'b1;
      pipe_out = 64'h0bad_0bad;
    end else if (pq.size() > 0 && (cyc - pq[0].c) >= 6 && (!hold || rel_req != rel_done)) begin
      p = pq.pop_front();
      pipe_out_valid = 1'b1;
      pipe_out = p.data;
      if (hold) rel_done++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((sb.size() != 0 || pq.size() != 0) && k < 60) begin
      step();
      k++;
    end
    chk("drain_sb", 64'(sb.size()), 64'(0));
    step();
    chk("drain_inflight", 64'(inflight), 64'(0));
  endtask

  task automatic rand_ops();
    req0_a = 31'($urandom); req0_b = 31'($urandom); req0_c = $urandom;
    req1_a = 31'($urandom); req1_b = 31'($urandom); req1_c = $urandom;
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_c = '0;
    req1_a = '0; req1_b = '0; req1_c = '0;
    pipe_out_valid = 1'b0; pipe_out = '0;

    // Reset values; no ready while in reset
    #2;
    chk("rst_ready0", 64'(req0_ready), 64'(0));
    chk("rst_pipe_in_valid", 64'(pipe_in_valid), 64'(0));
    chk("rst_inflight", 64'(inflight), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_resp_data", resp_data, 64'(0));
    req0_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();

    // Single op: 1+2 times 3, response 8 cycles after accept
    req0_a = 31'd1; req0_b = 31'd2; req0_c = 32'd3; req0_valid = 1'b1;
    #1;
    chk("single_ready0", 64'(req0_ready), 64'(1));
    chk("single_ready1", 64'(req1_ready), 64'(0));
    step();
    req0_valid = 1'b0;
    chk("single_issue_valid", 64'(pipe_in_valid), 64'(1));
    chk("single_issue_ops", {2'b0, pipe_in_1, pipe_in_2}, {2'b0, 31'd1, 31'd2});
    chk("single_issue_c", 64'(pipe_in_3), 64'(3));
    step();
    chk("single_issue_drop", 64'(pipe_in_valid), 64'(0));
    chk("single_issue_hold", 64'(pipe_in_3), 64'(3));
    k = 1;
    while (!resp0_valid && k < 20) begin
      step();
      k++;
    end
    chk("single_latency", 64'(k), 64'(7));
    chk("single_resp_data", resp_data, 64'd9);
    chk("single_resp1", 64'(resp1_valid), 64'(0));
    step();
    chk("single_resp_pulse", 64'(resp0_valid), 64'(0));
    chk("single_resp_hold", resp_data, 64'd9);
    wait_drain();

    // Both valid continuously after reset: grants alternate starting with req0
    do_reset();
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rand_ops();
      #1;
      chk("rr_ready0", 64'(req0_ready), 64'(i % 2 == 0));
      chk("rr_ready1", 64'(req1_ready), 64'(i % 2 == 1));
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_drain();

    // Fill the FIFO with results withheld, then free one slot
    hold = 1'b1;
    req0_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rand_ops();
      #1;
      chk("fill_ready0", 64'(req0_ready), 64'(1));
      step();
    end
    req1_valid = 1'b1;
    rel_req++;
    #1;
    chk("full_inflight", 64'(inflight), 64'(8));
    chk("full_ready0", 64'(req0_ready), 64'(0));
    chk("full_ready1", 64'(req1_ready), 64'(0));
    step();
    chk("pop_inflight", 64'(inflight), 64'(7));
    chk("pop_ready1", 64'(req1_ready), 64'(1));
    chk("pop_ready0", 64'(req0_ready), 64'(0));
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();

    // Push and pop together at occupancy 4; oldest (req0) tag is routed
    rel_req += 3;
    k = 0;
    while (inflight != 4'd4 && k < 10) begin
      step();
      k++;
    end
    chk("pp_pre_inflight", 64'(inflight), 64'(4));
    rand_ops();
    req1_valid = 1'b1;
    rel_req++;
    #1;
    chk("pp_ready1", 64'(req1_ready), 64'(1));
    step();
    req1_valid = 1'b0;
    chk("pp_inflight", 64'(inflight), 64'(4));
    chk("pp_resp0", 64'(resp0_valid), 64'(1));
    chk("pp_resp1", 64'(resp1_valid), 64'(0));
    hold = 1'b0;
    wait_drain();

    // Result with empty FIFO: sticky error, no response
    chk("spur_err_pre", 64'(err), 64'(0));
    spur_req++;
    step();
    chk("spur_err", 64'(err), 64'(1));
    chk("spur_resp", {62'b0, resp1_valid, resp0_valid}, 64'(0));
    chk("spur_inflight", 64'(inflight), 64'(0));
    step(); step(); step();
    chk("spur_err_sticky", 64'(err), 64'(1));

    // Reset with three ops in flight
    req0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_ops();
      step();
    end
    req1_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pipe_in_valid", 64'(pipe_in_valid), 64'(0));
    chk("mid_rst_pipe_in_1", 64'(pipe_in_1), 64'(0));
    chk("mid_rst_inflight", 64'(inflight), 64'(0));
    chk("mid_rst_err", 64'(err), 64'(0));
    chk("mid_rst_resp_data", resp_data, 64'(0));
    chk("mid_rst_ready", {62'b0, req1_ready, req0_ready}, 64'(0));
    step();
    step();
    rst_n = 1'b1;
    rand_ops();
    #1;
    chk("post_rst_ready0", 64'(req0_ready), 64'(1));
    chk("post_rst_ready1", 64'(req1_ready), 64'(0));
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
